vertex_simd_core: RTL

VERTEX_SIMD_CORE -- requirements
Module: vertex_simd_core

---
 rtl/vertex_simd_core_pkg.sv | 44 ++++
 rtl/simd_lane_alu.sv | 31 +++
 rtl/vertex_simd_core.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vertex_simd_core_pkg.sv
// Shared opcode, state and default-parameter definitions for the vertex SIMD core.
package vertex_simd_core_pkg;

  localparam int LANES_DEF   = 4;
  localparam int LANE_W_DEF  = 32;
  localparam int IMEM_AW_DEF = 8;
  localparam int DMEM_AW_DEF = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_ADDI = 4'd7,
    OP_DOT  = 4'd8,
    OP_LD   = 4'd9,
    OP_ST   = 4'd10,
    OP_OUT  = 4'd11,
    OP_JNZ  = 4'd12,
    OP_RSV0 = 4'd13,
    OP_RSV1 = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_OUT_WAIT
  } state_e;

  // 16-bit instruction word: op | rd | rs1 | rs2/imm4
  typedef struct packed {
    opcode_e    op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

endpackage

// File: rtl/simd_lane_alu.sv
// Single-lane arithmetic unit; every lane wraps modulo 2^LANE_W.
module simd_lane_alu
  import vertex_simd_core_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  opcode_e           op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [3:0]        imm4,
  output logic [LANE_W-1:0] res,
  output logic [LANE_W-1:0] prod
);

  // Per-lane result; prod is also exported for the core's DOT reduction.
  always_comb begin
    prod = a * b;
    res  = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = prod;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_ADDI: res = a + {{(LANE_W-4){imm4[3]}}, imm4};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/vertex_simd_core.sv
// Vertex SIMD core: 16 x VW register file, host-loaded imem/dmem, streamed output.
module vertex_simd_core
  import vertex_simd_core_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int LANE_W  = LANE_W_DEF,
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int DMEM_AW = DMEM_AW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    we_ins_m,
  input  logic [IMEM_AW-1:0]      addr_ins_m,
  input  logic [15:0]             din_ins_m,
  input  logic                    we_inf,
  input  logic [DMEM_AW-1:0]      addr_inf,
  input  logic [LANES*LANE_W-1:0] info_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] vert_out
);

  localparam int VW = LANES * LANE_W;

  logic [15:0]   imem [2**IMEM_AW];
  logic [VW-1:0] dmem [2**DMEM_AW];

  logic [15:0][VW-1:0]          regs;
  state_e                       state, state_nx;
  logic [IMEM_AW-1:0]           pc;
  instr_t                       ir;
  logic [VW-1:0]                mem_q;
  logic [LANES-1:0][LANE_W-1:0] va, vb, vres, vprod;
  logic [LANE_W-1:0]            dot_sum;
  logic [VW-1:0]                dot_res;
  logic [7:0]                   addr8;
  logic [DMEM_AW-1:0]           daddr;
  logic                         exec_ld, exec_st;

  assign busy    = (state != S_IDLE);
  assign va      = regs[ir.rs1];
  assign vb      = regs[ir.rs2];
  assign addr8   = {ir.rs1, ir.rs2};
  assign daddr   = addr8[DMEM_AW-1:0];
  assign exec_ld = (state == S_EXEC) && (ir.op == OP_LD);
  assign exec_st = (state == S_EXEC) && (ir.op == OP_ST);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
      .op   (ir.op),
      .a    (va[i]),
      .b    (vb[i]),
      .imm4 (ir.rs2),
      .res  (vres[i]),
      .prod (vprod[i])
    );
  end

  // DOT: wrapped sum of lane products lands in lane 0, other lanes zero.
  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < LANES; i++) dot_sum = dot_sum + vprod[i];
    dot_res = '0;
    dot_res[LANE_W-1:0] = dot_sum;
  end

  // Instruction memory: host writes only while idle; synchronous fetch read.
  always_ff @(posedge clk) begin
    if (we_ins_m && !busy) imem[addr_ins_m] <= din_ins_m;
    if (state == S_FETCH) ir <= instr_t'(imem[pc]);
  end

  // Data memory: host writes while idle, ST while running; LD read registered.
  always_ff @(posedge clk) begin
    if (we_inf && !busy) dmem[addr_inf] <= info_in;
    else if (exec_st)    dmem[daddr]    <= regs[ir.rd];
    if (exec_ld) mem_q <= dmem[daddr];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_FETCH;
      S_FETCH:    state_nx = S_EXEC;
      S_EXEC: begin
        case (ir.op)
          OP_LD:   state_nx = S_MEM;
          OP_OUT:  state_nx = S_OUT_WAIT;
          OP_HALT: state_nx = S_IDLE;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEM:      state_nx = S_FETCH;
      S_OUT_WAIT: if (out_ready) state_nx = S_FETCH;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Datapath: pc, register writeback, output holding register and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      regs      <= '0;
      out_valid <= 1'b0;
      vert_out  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) pc <= '0;
        S_EXEC: begin
          pc <= pc + 1'b1;
          case (ir.op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND,
            OP_OR, OP_XOR, OP_ADDI: regs[ir.rd] <= vres;
            OP_DOT: regs[ir.rd] <= dot_res;
            OP_OUT: begin
              vert_out  <= regs[ir.rd];
              out_valid <= 1'b1;
            end
            OP_JNZ:  if (regs[ir.rd][LANE_W-1:0] != '0) pc <= IMEM_AW'(addr8);
            OP_HALT: done <= 1'b1;
            default: ;
          endcase
        end
        S_MEM:      regs[ir.rd] <= mem_q;
        S_OUT_WAIT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
